// File: rtl/cpu_axi_bridge_if.sv
// AXI3 master-side bundle between cpu_axi_bridge and the interconnect.
// Fixed fields (len, burst, lock, cache, prot) are tied off at SoC top.
interface cpu_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arsize, arvalid, rready,
    output awid, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rid, rdata, rvalid, awready, wready, bvalid
  );

  modport slave (
    input  arid, araddr, arsize, arvalid, rready,
    input  awid, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rid, rdata, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/cpu_axi_bridge.sv
// Bridges split inst/data SRAM-like requests onto one AXI3 master port,
// one transaction in flight, data side arbitrated ahead of instruction side.
module cpu_axi_bridge #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  cpu_axi_bridge_if.master axi
);

  typedef enum logic [2:0] {S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_inst_rdata, r_data_rdata;
  logic [1:0]  r_size;
  logic [3:0]  r_id, r_wstrb;
  logic        r_aw_done, r_w_done;

  logic w_arvalid, w_rready, w_awvalid, w_wvalid, w_bready;
  logic w_inst_addr_ok, w_data_addr_ok, w_inst_data_ok, w_data_data_ok;
  logic w_aw_fire, w_w_fire;
  logic [1:0] w_data_size;
  logic [3:0] w_data_wstrb;

  // Size 3 is illegal and is handled as a word access.
  assign w_data_size = (data_size == 2'd3) ? 2'd2 : data_size;

  always_comb begin
    case (w_data_size)
      2'd0:    w_data_wstrb = 4'b0001 << data_addr[1:0];
      2'd1:    w_data_wstrb = 4'b0011 << {data_addr[1], 1'b0};
      default: w_data_wstrb = 4'b1111;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next         = r_state;
    w_inst_addr_ok = 1'b0;
    w_data_addr_ok = 1'b0;
    w_inst_data_ok = 1'b0;
    w_data_data_ok = 1'b0;
    w_arvalid      = 1'b0;
    w_rready       = 1'b0;
    w_awvalid      = 1'b0;
    w_wvalid       = 1'b0;
    w_bready       = 1'b0;
    w_aw_fire      = 1'b0;
    w_w_fire       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (data_req) begin
          w_data_addr_ok = 1'b1;
          w_next         = data_wr ? S_WR_REQ : S_RD_ADDR;
        end else if (inst_req) begin
          w_inst_addr_ok = 1'b1;
          w_next         = S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        w_arvalid = 1'b1;
        if (axi.arready) w_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        w_rready = 1'b1;
        if (axi.rvalid) begin
          w_data_data_ok = (r_id == ID_DATA);
          w_inst_data_ok = (r_id != ID_DATA);
          w_next         = S_IDLE;
        end
      end
      S_WR_REQ: begin
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
        w_aw_fire = w_awvalid && axi.awready;
        w_w_fire  = w_wvalid && axi.wready;
        if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) w_next = S_WR_RESP;
      end
      S_WR_RESP: begin
        w_bready = 1'b1;
        if (axi.bvalid) begin
          w_data_data_ok = 1'b1;
          w_next         = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= '0;
      r_id         <= '0;
      r_wstrb      <= '0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_data_addr_ok) begin
        r_addr    <= data_addr;
        r_wdata   <= data_wdata;
        r_size    <= w_data_size;
        r_id      <= ID_DATA;
        r_wstrb   <= w_data_wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else if (w_inst_addr_ok) begin
        r_addr  <= inst_addr;
        r_wdata <= '0;
        r_size  <= 2'd2;
        r_id    <= ID_INST;
        r_wstrb <= '0;
      end
      if (w_aw_fire) r_aw_done <= 1'b1;
      if (w_w_fire)  r_w_done  <= 1'b1;
      if (w_inst_data_ok) r_inst_rdata <= axi.rdata;
      if (w_data_data_ok && r_state == S_RD_DATA) r_data_rdata <= axi.rdata;
    end
  end

  // Returned read ID must match the transaction we issued.
  a_rid_match: assert property (@(posedge clk) disable iff (!resetn)
    (r_state == S_RD_DATA && axi.rvalid) |-> (axi.rid == r_id));

  assign inst_addr_ok = w_inst_addr_ok;
  assign data_addr_ok = w_data_addr_ok;
  assign inst_data_ok = w_inst_data_ok;
  assign data_data_ok = w_data_data_ok;
  // Read data is valid during its pulse and holds afterwards.
  assign inst_rdata   = w_inst_data_ok ? axi.rdata : r_inst_rdata;
  assign data_rdata   = (w_data_data_ok && r_state == S_RD_DATA) ? axi.rdata : r_data_rdata;

  assign axi.arid    = r_id;
  assign axi.araddr  = r_addr;
  assign axi.arsize  = {1'b0, r_size};
  assign axi.arvalid = w_arvalid;
  assign axi.rready  = w_rready;
  assign axi.awid    = r_id;
  assign axi.awaddr  = r_addr;
  assign axi.awsize  = {1'b0, r_size};
  assign axi.awvalid = w_awvalid;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_wstrb;
  assign axi.wvalid  = w_wvalid;
  assign axi.bready  = w_bready;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: reset, reads, stores, arbitration,
// split write handshakes, mid-transaction reset and back-to-back fetches.
module tb_cpu_axi_bridge;
  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  int          n_assert = 0;
  int          n_fail   = 0;

  cpu_axi_bridge_if axi ();

  cpu_axi_bridge #(.ID_INST(4'd0), .ID_DATA(4'd1)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .axi          (axi.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_wr = 0; data_size = '0; data_addr = '0; data_wdata = '0;
    axi.arready = 0; axi.rid = '0; axi.rdata = '0; axi.rvalid = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
    tick(); tick();
    #1;
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_rready", axi.rready, 0);
    chk("rst_bready", axi.bready, 0);
    chk("rst_araddr", axi.araddr, 32'h0);
    chk("rst_wstrb", axi.wstrb, 0);
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    resetn = 1'b1;

    // Instruction fetch, zero-wait slave
    tick(); inst_req = 1; inst_addr = 32'hBFC0_0000; #1;
    chk("t1_inst_addr_ok", inst_addr_ok, 1);
    chk("t1_data_addr_ok", data_addr_ok, 0);
    tick(); inst_req = 0; axi.arready = 1; #1;
    chk("t1_arvalid", axi.arvalid, 1);
    chk("t1_araddr", axi.araddr, 32'hBFC0_0000);
    chk("t1_arid", axi.arid, 0);
    chk("t1_arsize", axi.arsize, 2);
    chk("t1_addr_ok_busy", inst_addr_ok, 0);
    tick(); axi.arready = 0; axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'h3C1D_0001; #1;
    chk("t1_rready", axi.rready, 1);
    chk("t1_arvalid_low", axi.arvalid, 0);
    chk("t1_inst_data_ok", inst_data_ok, 1);
    chk("t1_inst_rdata", inst_rdata, 32'h3C1D_0001);
    chk("t1_data_data_ok", data_data_ok, 0);
    tick(); axi.rvalid = 0; axi.rdata = '0; #1;
    chk("t1_data_ok_pulse", inst_data_ok, 0);
    chk("t1_rdata_hold", inst_rdata, 32'h3C1D_0001);
    chk("t1_rready_low", axi.rready, 0);

    // Byte store at lane 3
    tick(); data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h8000_0003;
    data_wdata = 32'hAB00_0000; #1;
    chk("t2_data_addr_ok", data_addr_ok, 1);
    tick(); data_req = 0; axi.awready = 1; axi.wready = 1; #1;
    chk("t2_awvalid", axi.awvalid, 1);
    chk("t2_wvalid", axi.wvalid, 1);
    chk("t2_awsize", axi.awsize, 0);
    chk("t2_wstrb", axi.wstrb, 4'b1000);
    chk("t2_awaddr", axi.awaddr, 32'h8000_0003);
    chk("t2_awid", axi.awid, 1);
    chk("t2_wdata", axi.wdata, 32'hAB00_0000);
    tick(); axi.awready = 0; axi.wready = 0; axi.bvalid = 1; #1;
    chk("t2_bready", axi.bready, 1);
    chk("t2_awvalid_low", axi.awvalid, 0);
    chk("t2_wvalid_low", axi.wvalid, 0);
    chk("t2_data_data_ok", data_data_ok, 1);
    tick(); axi.bvalid = 0; #1;
    chk("t2_data_ok_pulse", data_data_ok, 0);
    chk("t2_bready_low", axi.bready, 0);

    // Simultaneous requests: data wins, inst waits for a later IDLE cycle
    tick(); inst_req = 1; inst_addr = 32'h0000_0100;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h0000_1000; #1;
    chk("t3_data_first", data_addr_ok, 1);
    chk("t3_inst_blocked", inst_addr_ok, 0);
    tick(); data_req = 0; axi.arready = 1; #1;
    chk("t3_arvalid", axi.arvalid, 1);
    chk("t3_arid", axi.arid, 1);
    chk("t3_araddr", axi.araddr, 32'h0000_1000);
    chk("t3_inst_wait_ar", inst_addr_ok, 0);
    tick(); axi.arready = 0; axi.rvalid = 1; axi.rid = 1; axi.rdata = 32'hDEAD_BEEF; #1;
    chk("t3_data_data_ok", data_data_ok, 1);
    chk("t3_data_rdata", data_rdata, 32'hDEAD_BEEF);
    chk("t3_inst_data_ok", inst_data_ok, 0);
    chk("t3_inst_wait_r", inst_addr_ok, 0);
    tick(); axi.rvalid = 0; axi.rdata = '0; #1;
    chk("t3_inst_addr_ok", inst_addr_ok, 1);
    chk("t3_data_rdata_hold", data_rdata, 32'hDEAD_BEEF);
    tick(); inst_req = 0; axi.arready = 1; #1;
    chk("t3_inst_araddr", axi.araddr, 32'h0000_0100);
    chk("t3_inst_arid", axi.arid, 0);
    tick(); axi.arready = 0; axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'h1122_3344; #1;
    chk("t3_inst_ok", inst_data_ok, 1);
    chk("t3_inst_rdata", inst_rdata, 32'h1122_3344);
    tick(); axi.rvalid = 0; axi.rdata = '0; #1;

    // Half-word store at 0x2 with awready at cycle 1, wready at cycle 4
    tick(); data_req = 1; data_wr = 1; data_size = 1; data_addr = 32'h0000_0002;
    data_wdata = 32'h5566_0000; #1;
    chk("t4_addr_ok", data_addr_ok, 1);
    tick(); data_req = 0; axi.awready = 1; #1;
    chk("t4_c1_awvalid", axi.awvalid, 1);
    chk("t4_c1_wvalid", axi.wvalid, 1);
    chk("t4_wstrb", axi.wstrb, 4'b1100);
    chk("t4_awsize", axi.awsize, 1);
    tick(); axi.awready = 0; #1;
    chk("t4_c2_awvalid", axi.awvalid, 0);
    chk("t4_c2_wvalid", axi.wvalid, 1);
    chk("t4_c2_bready", axi.bready, 0);
    tick(); #1;
    chk("t4_c3_wvalid", axi.wvalid, 1);
    tick(); axi.wready = 1; #1;
    chk("t4_c4_wvalid", axi.wvalid, 1);
    chk("t4_c4_awvalid", axi.awvalid, 0);
    tick(); axi.wready = 0; #1;
    chk("t4_c5_bready", axi.bready, 1);
    chk("t4_c5_wvalid", axi.wvalid, 0);
    chk("t4_c5_no_ok", data_data_ok, 0);
    tick(); axi.bvalid = 1; #1;
    chk("t4_data_ok", data_data_ok, 1);
    tick(); axi.bvalid = 0; #1;
    chk("t4_data_ok_pulse", data_data_ok, 0);
    chk("t4_bready_low", axi.bready, 0);

    // Reset while waiting in the read-data phase
    tick(); inst_req = 1; inst_addr = 32'h0000_0200; #1;
    chk("t5_addr_ok", inst_addr_ok, 1);
    tick(); inst_req = 0; axi.arready = 1; #1;
    tick(); axi.arready = 0; #1;
    chk("t5_rready", axi.rready, 1);
    resetn = 0;
    tick(); resetn = 1; #1;
    chk("t5_rready_cleared", axi.rready, 0);
    chk("t5_arvalid_cleared", axi.arvalid, 0);
    chk("t5_awvalid_cleared", axi.awvalid, 0);
    chk("t5_inst_rdata_cleared", inst_rdata, 32'h0);
    axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'h0000_0099; #1;
    chk("t5_late_rvalid_inst", inst_data_ok, 0);
    chk("t5_late_rvalid_data", data_data_ok, 0);
    tick(); axi.rvalid = 0; axi.rdata = '0; #1;
    chk("t5_after_inst_ok", inst_data_ok, 0);
    chk("t5_after_rdata", inst_rdata, 32'h0);

    // Back-to-back fetches, zero-wait slave: a 3-cycle accept/address/data rhythm
    tick(); inst_req = 1; inst_addr = 32'h0000_0400;
    axi.arready = 1; axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'hCAFE_0000; #1;
    for (int c = 0; c < 9; c++) begin
      if (c != 0) tick();
      chk($sformatf("t6_addr_ok_c%0d", c), inst_addr_ok, (c % 3 == 0));
      chk($sformatf("t6_arvalid_c%0d", c), axi.arvalid, (c % 3 == 1));
      chk($sformatf("t6_data_ok_c%0d", c), inst_data_ok, (c % 3 == 2));
    end
    inst_req = 0; axi.arready = 0; axi.rvalid = 0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
